spram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the single-port RAM (single_port_ram, shared inout data bus, cs/wr/oe control).
- Accepts independent read/write commands from two clients over req/ack handshakes and serialises them onto the one RAM port.
- Generates cs/wr/oe with the RAM's registered-read timing and owns the tri-state data bus direction.
- Sits between the RAM and two bus clients, for example a CPU-side port and a DMA-side port.

---
 rtl/spram_arb_pkg.sv | 16 +
 rtl/spram_arbiter_rr_pick2.sv | 21 ++
 rtl/spram_arbiter.sv | 114 +++++++++++
 tb/tb_spram_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-client single-port RAM arbiter.
//   state_t : sequencer state encoding (3 bits)
//   NUM_REQ : number of requesting clients
package spram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/spram_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational.
//   req      : per-client request
//   last_gnt : client granted most recently
//   valid    : at least one request present
//   sel      : chosen client index
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        // Under contention the client that was not served last wins;
        // otherwise the lone requester (or 0 when idle) is selected.
        if (req == 2'b11) sel = ~last_gnt;
        else              sel = req[1];
    end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter and sequencer for one single-port RAM shared by
// two clients. Commands are latched on grant and replayed on the RAM port
// with registered-read timing.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req/we/addr/wdata: per-client command (client i in slice i)
//   ack              : one-hot completion pulse to the granted client
//   rdata            : read result, valid with ack of a read
//   busy             : sequencer not idle
//   ram_cs/wr/oe     : RAM control strobes, decoded from state only
//   ram_addr         : RAM address (latched on grant)
//   ram_data         : bidirectional RAM data bus, driven only in WR
//
// state   | meaning
// IDLE    | waiting for a request; grants and latches command
// WR      | write strobe, bus driven with latched data
// RD1     | RAM loads its internal read register
// RD2     | RAM drives bus, result captured into rdata
// DONE    | controls low, ack to granted client
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          ram_cs,
    output logic                          ram_wr,
    output logic                          ram_oe,
    output logic [ADDR_SIZE-1:0]          ram_addr,
    inout  wire  [DATA_WIDTH-1:0]         ram_data
);

    state_t                 state, state_nx;
    logic                   sel_q;
    logic                   last_gnt;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   pick_valid;
    logic                   pick_sel;

    rr_pick2 u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .sel      (pick_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_q    <= 1'b0;
            last_gnt <= 1'b1;
            wdata_q  <= '0;
            ram_addr <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && pick_valid) begin
                sel_q    <= pick_sel;
                last_gnt <= pick_sel;
                ram_addr <= pick_sel ? addr[2*ADDR_SIZE-1:ADDR_SIZE]
                                     : addr[ADDR_SIZE-1:0];
                wdata_q  <= pick_sel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : wdata[DATA_WIDTH-1:0];
            end
            if (state == ST_RD2) rdata <= ram_data;
        end
    end

    always_comb begin
        state_nx = state;
        ram_cs   = 1'b0;
        ram_wr   = 1'b0;
        ram_oe   = 1'b0;
        ack      = '0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_valid)
                    state_nx = (pick_sel ? we[1] : we[0]) ? ST_WR : ST_RD1;
            end
            ST_WR: begin
                ram_cs   = 1'b1;
                ram_wr   = 1'b1;
                state_nx = ST_DONE;
            end
            ST_RD1: begin
                ram_cs   = 1'b1;
                state_nx = ST_RD2;
            end
            ST_RD2: begin
                ram_cs   = 1'b1;
                ram_oe   = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                ack      = sel_q ? 2'b10 : 2'b01;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The bus is driven strictly in WR, so it can never overlap RD2 (oe).
    assign ram_data = (state == ST_WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic        ram_cs;
    logic        ram_wr;
    logic        ram_oe;
    logic [3:0]  ram_addr;
    wire  [7:0]  ram_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.DATA_WIDTH(8), .ADDR_SIZE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .ram_cs   (ram_cs),
        .ram_wr   (ram_wr),
        .ram_oe   (ram_oe),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    // Behavioural single-port RAM with registered read.
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] rreg = 8'h00;

    always @(posedge clk) begin
        if (ram_cs && ram_wr)  mem[ram_addr] <= ram_data;
        else if (ram_cs)       rreg <= mem[ram_addr];
    end

    assign ram_data = (ram_cs && ram_oe && !ram_wr) ? rreg : 8'hzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic issue(input int c, input logic w, input logic [3:0] a, input logic [7:0] d);
        req[c]         = 1'b1;
        we[c]          = w;
        addr[c*4 +: 4] = a;
        wdata[c*8 +: 8] = d;
    endtask

    // One complete transaction for a single client: latency, ack and
    // (for reads) data are all checked; req is released after ack.
    task automatic do_op(input string tag, input int c, input logic w,
                         input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        n = 0;
        issue(c, w, a, d);
        for (int k = 0; k < 8; k++) begin
            tick();
            n++;
            if (ack != 2'b00) break;
        end
        check({tag, "_lat"}, n, w ? 2 : 3);
        check({tag, "_ack"}, ack, (c == 1) ? 2'b10 : 2'b01);
        if (!w) check({tag, "_rd"}, rdata, exp_rd);
        tick();
        req[c] = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_ack;
        int         n;

        // reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b000);
        check("rst_addr", ram_addr, 0);
        check("rst_rdata", rdata, 0);
        do_reset();

        // test 1: client 0 write addr 3 / 0xA5
        issue(0, 1'b1, 4'd3, 8'hA5);
        tick();
        check("t1_wr_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b110);
        check("t1_wr_data", ram_data, 8'hA5);
        check("t1_wr_addr", ram_addr, 3);
        check("t1_wr_ack", ack, 0);
        tick();
        check("t1_done_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b000);
        check("t1_ack", ack, 2'b01);
        tick();
        req[0] = 1'b0;
        check("t1_ack_pulse", ack, 0);
        check("t1_mem", mem[3], 8'hA5);

        // test 2: client 1 reads addr 3
        issue(1, 1'b0, 4'd3, 8'h00);
        tick();
        check("t2_rd1_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b100);
        check("t2_rd1_ack", ack, 0);
        tick();
        check("t2_rd2_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b101);
        tick();
        check("t2_done_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b000);
        check("t2_ack", ack, 2'b10);
        check("t2_rdata", rdata, 8'hA5);
        tick();
        req[1] = 1'b0;
        check("t2_idle", busy, 0);

        // test 3: simultaneous writes after reset
        do_reset();
        issue(0, 1'b1, 4'd1, 8'h11);
        issue(1, 1'b1, 4'd2, 8'h22);
        tick();
        check("t3_c0_addr", ram_addr, 1);
        check("t3_c0_data", ram_data, 8'h11);
        tick();
        check("t3_c0_ack", ack, 2'b01);
        tick();
        req[0] = 1'b0;
        tick();
        check("t3_c1_addr", ram_addr, 2);
        check("t3_c1_data", ram_data, 8'h22);
        tick();
        check("t3_c1_ack", ack, 2'b10);
        tick();
        req[1] = 1'b0;
        do_op("t3_rb1", 0, 1'b0, 4'd1, 8'h00, 8'h11);
        do_op("t3_rb2", 1, 1'b0, 4'd2, 8'h00, 8'h22);

        // test 4: both hold req for 6 back-to-back reads
        do_reset();
        issue(0, 1'b0, 4'd1, 8'h00);
        issue(1, 1'b0, 4'd2, 8'h00);
        exp_ack = 2'b01;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            for (int j = 0; j < 8; j++) begin
                tick();
                n++;
                if (ack != 2'b00) break;
            end
            check("t4_lat", n, (k == 0) ? 3 : 4);
            check("t4_ack", ack, exp_ack);
            check("t4_rdata", rdata, (exp_ack == 2'b01) ? 8'h11 : 8'h22);
            exp_ack = ~exp_ack;
        end
        tick();
        req = 2'b00;
        tick();
        check("t4_idle", busy, 0);

        // test 5: reset during WR suppresses the write
        issue(0, 1'b1, 4'd5, 8'hFF);
        tick();
        check("t5_wr_cs", ram_cs, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {ram_cs, ram_wr, ram_oe}, 3'b000);
        check("t5_rst_busy", busy, 0);
        req = 2'b00;
        tick();
        check("t5_rst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack != 2'b00) n++;
        end
        check("t5_no_ack", n, 0);
        check("t5_mem", mem[5], 8'h00);
        do_op("t5_rb", 0, 1'b0, 4'd5, 8'h00, 8'h00);

        // test 6: input changes while busy are ignored
        issue(0, 1'b1, 4'd7, 8'h3C);
        tick();
        addr[3:0]  = 4'd9;
        wdata[7:0] = 8'hC3;
        #1;
        check("t6_addr", ram_addr, 7);
        check("t6_data", ram_data, 8'h3C);
        tick();
        check("t6_ack", ack, 2'b01);
        check("t6_addr_hold", ram_addr, 7);
        tick();
        req[0] = 1'b0;
        do_op("t6_rb7", 1, 1'b0, 4'd7, 8'h00, 8'h3C);
        do_op("t6_rb9", 1, 1'b0, 4'd9, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
